// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if: display-word load handshake and scanned digit outputs
interface seven_seg_scan_driver_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] i_value;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic                    i_load;
  logic                    i_blankLz;
  logic [3:0]              o_digitVal;
  logic                    o_dp;
  logic                    o_blank;
  logic [NUM_DIGITS-1:0]   o_digitSel;
  logic                    o_frame;
  logic                    o_loadAck;
  modport master(
    output i_value, i_dp, i_load, i_blankLz,
    input  o_digitVal, o_dp, o_blank, o_digitSel, o_frame, o_loadAck
  );
  modport slave(
    input  i_value, i_dp, i_load, i_blankLz,
    output o_digitVal, o_dp, o_blank, o_digitSel, o_frame, o_loadAck
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed 7-segment scan with frame-synchronous loads
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input logic i_clk,
  input logic i_reset,
  seven_seg_scan_driver_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d, pend_dp_q, pend_dp_d, sel_q, sel_d, lz;
  logic pend_q, pend_d, frame_q, frame_d, ack_q, ack_d;
  logic [3:0] digit_val_q, digit_val_d;
  logic dp_out_q, dp_out_d, blank_q, blank_d;
  logic tc, wrap, in_blank, z;
  always_comb begin
    tc = presc_q == PW'(CLK_DIV - 1);
    wrap = tc && idx_q == IW'(NUM_DIGITS - 1);
    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d = tc ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    // a load landing on the wrap cycle bypasses pending and commits with this frame
    disp_d = wrap ? (bus.i_load ? bus.i_value : pend_q ? pend_val_q : disp_q) : disp_q;
    dp_d = wrap ? (bus.i_load ? bus.i_dp : pend_q ? pend_dp_q : dp_q) : dp_q;
    pend_d = wrap ? 1'b0 : (pend_q | bus.i_load);
    pend_val_d = bus.i_load ? bus.i_value : pend_val_q;
    pend_dp_d = bus.i_load ? bus.i_dp : pend_dp_q;
    frame_d = wrap;
    ack_d = wrap & (pend_q | bus.i_load);
    lz = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z & (disp_q[i*4 +: 4] == 4'd0);
      lz[i] = z;
    end
    lz[0] = 1'b0;
    in_blank = presc_q < PW'(BLANK_CYCLES);
    digit_val_d = disp_q[{idx_q, 2'b00} +: 4];
    dp_out_d = dp_q[idx_q];
    blank_d = in_blank | (bus.i_blankLz & lz[idx_q] & ~dp_q[idx_q]);
    sel_d = (in_blank ? '0 : ONE << idx_q) ^ SEL_OFF;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_q <= '0;
      idx_q <= '0;
      disp_q <= '0;
      dp_q <= '0;
      pend_val_q <= '0;
      pend_dp_q <= '0;
      pend_q <= 1'b0;
      frame_q <= 1'b0;
      ack_q <= 1'b0;
      digit_val_q <= '0;
      dp_out_q <= 1'b0;
      blank_q <= 1'b1;
      sel_q <= SEL_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q <= idx_d;
      disp_q <= disp_d;
      dp_q <= dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q <= pend_dp_d;
      pend_q <= pend_d;
      frame_q <= frame_d;
      ack_q <= ack_d;
      digit_val_q <= digit_val_d;
      dp_out_q <= dp_out_d;
      blank_q <= blank_d;
      sel_q <= sel_d;
    end
  end
  assign bus.o_digitVal = digit_val_q;
  assign bus.o_dp = dp_out_q;
  assign bus.o_blank = blank_q;
  assign bus.o_digitSel = sel_q;
  assign bus.o_frame = frame_q;
  assign bus.o_loadAck = ack_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: cycle-count model of the scan plus directed literal checks
module tb_seven_seg_scan_driver;
  localparam int N = 4, DIV = 4, BL = 1, FRAME = N * DIV;
  logic clk = 1'b0, rst = 1'b1;
  int passed = 0, total = 0;
  seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus();
  seven_seg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BL), .SEL_ACTIVE_LOW(1)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // model: k counts clock edges since reset; outputs after edge k describe position (k-1) of the frame
  int k, p, slot, hi;
  logic [15:0] m_disp, m_pv;
  logic [3:0] m_ddp, m_pdp, e_val, e_sel;
  logic m_pend, e_dp, e_blank, e_frame, e_ack;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      k = 0; m_disp = 0; m_pv = 0; m_ddp = 0; m_pdp = 0; m_pend = 0;
      e_val = 0; e_sel = 4'hF; e_dp = 0; e_blank = 1; e_frame = 0; e_ack = 0;
    end else begin
      p = k % FRAME;
      slot = p / DIV;
      hi = -1;
      for (int i = 0; i < N; i++) if (m_disp[i*4 +: 4] != 4'd0) hi = i;
      e_val = m_disp[slot*4 +: 4];
      e_dp = m_ddp[slot];
      e_blank = (p % DIV) < BL || (bus.i_blankLz && slot != 0 && slot > hi && !m_ddp[slot]);
      e_sel = (p % DIV) < BL ? 4'hF : ~(4'b0001 << slot);
      e_frame = p == FRAME - 1;
      e_ack = e_frame && (m_pend || bus.i_load);
      if (e_frame) begin
        if (bus.i_load) begin m_disp = bus.i_value; m_ddp = bus.i_dp; end
        else if (m_pend) begin m_disp = m_pv; m_ddp = m_pdp; end
        m_pend = 0;
      end else if (bus.i_load) begin
        m_pv = bus.i_value; m_pdp = bus.i_dp; m_pend = 1;
      end
      k++;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("val", bus.o_digitVal, e_val);
    chk("dp", bus.o_dp, e_dp);
    chk("blank", bus.o_blank, e_blank);
    chk("sel", bus.o_digitSel, e_sel);
    chk("frame", bus.o_frame, e_frame);
    chk("ack", bus.o_loadAck, e_ack);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    bus.i_value = v; bus.i_dp = d; bus.i_load = 1'b1;
    @(negedge clk);
    bus.i_load = 1'b0;
  endtask

  task automatic wait_frame;
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.o_frame && n < 40);
    chk("frame_seen", bus.o_frame, 1);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_val"}, bus.o_digitVal, 0);
    chk({tag, "_dp"}, bus.o_dp, 0);
    chk({tag, "_blank"}, bus.o_blank, 1);
    chk({tag, "_sel"}, bus.o_digitSel, 4'b1111);
    chk({tag, "_frame"}, bus.o_frame, 0);
    chk({tag, "_ack"}, bus.o_loadAck, 0);
  endtask

  // called on the o_frame cycle; ends on digit 3's first visible cycle
  task automatic scan(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] dm);
    logic [3:0] sels [4];
    sels = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int d = 0; d < 4; d++) begin
      step(d == 0 ? 2 : 4);
      chk("scan_val", bus.o_digitVal, v[d*4 +: 4]);
      chk("scan_sel", bus.o_digitSel, sels[d]);
      chk("scan_blank", bus.o_blank, bm[d]);
      chk("scan_dp", bus.o_dp, dm[d]);
    end
  endtask

  initial begin
    bus.i_value = 0; bus.i_dp = 0; bus.i_load = 0; bus.i_blankLz = 0;
    step(3);
    reset_vals("reset");
    rst = 1'b0;
    step(1);
    chk("idle_blank_sel", bus.o_digitSel, 4'b1111);
    step(1);
    chk("idle_sel_d0", bus.o_digitSel, 4'b1110);
    step(36);
    load(16'h12AF, 4'b0000);
    chk("pre_commit_val", bus.o_digitVal, 0);
    wait_frame;
    chk("ack_12af", bus.o_loadAck, 1);
    scan(16'h12AF, 4'b0000, 4'b0000);
    step(3);
    load(16'h1111, 4'b0000);
    step(2);
    load(16'h2222, 4'b0000);
    wait_frame;
    chk("ack_2222", bus.o_loadAck, 1);
    scan(16'h2222, 4'b0000, 4'b0000);
    step(1);
    load(16'h00BE, 4'b0000);
    chk("coincident_frame", bus.o_frame, 1);
    chk("coincident_ack", bus.o_loadAck, 1);
    scan(16'h00BE, 4'b0000, 4'b0000);
    bus.i_blankLz = 1'b1;
    load(16'h0050, 4'b0000);
    wait_frame;
    scan(16'h0050, 4'b1100, 4'b0000);
    load(16'h0050, 4'b1000);
    wait_frame;
    scan(16'h0050, 4'b0100, 4'b1000);
    load(16'h0000, 4'b0000);
    wait_frame;
    scan(16'h0000, 4'b1110, 4'b0000);
    bus.i_blankLz = 1'b0;
    step(3);
    load(16'h1234, 4'b0000);
    step(1);
    #2 rst = 1'b1;
    #1 reset_vals("async_reset");
    @(negedge clk);
    rst = 1'b0;
    wait_frame;
    chk("no_ack_after_reset", bus.o_loadAck, 0);
    scan(16'h0000, 4'b0000, 4'b0000);
    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
